// File: rtl/ota_bitstream_decimator.sv
// Decimator for the OTA comparator bitstream: it synchronises bit_in, counts ones over
// a 2^WIN_LOG2-cycle window, and holds one saturated density sample per window.
module ota_bitstream_decimator #(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_LOG2    = 8,
  parameter int OUT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             bit_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int SHIFT = WIN_LOG2 - OUT_W;
  localparam logic [WIN_LOG2:0] SAT_MAX = (WIN_LOG2+1)'((1 << OUT_W) - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_bit_s;
  logic [WIN_LOG2-1:0]    wcnt_r;
  logic [WIN_LOG2:0]      ones_r;
  logic [WIN_LOG2:0]      total_s;
  logic                   win_end_s;
  logic                   ovr_set_s;

  // A full window of ones gives N, which needs one bit more than OUT_W when WIN_LOG2 == OUT_W.
  function automatic logic [OUT_W-1:0] scale_total(input logic [WIN_LOG2:0] total);
    logic [WIN_LOG2:0] q;
    q = total >> SHIFT;
    if (q > SAT_MAX) begin
      scale_total = {OUT_W{1'b1}};
    end else begin
      scale_total = q[OUT_W-1:0];
    end
  endfunction

  assign s_bit_s   = sync_r[SYNC_STAGES-1];
  assign total_s   = ones_r + {{WIN_LOG2{1'b0}}, s_bit_s};
  assign win_end_s = ena && (wcnt_r == {WIN_LOG2{1'b1}});
  assign ovr_set_s = win_end_s && out_valid && !out_ready;

  // Synchroniser chain for the asynchronous comparator output; it runs whether or not ena is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bit_in};
    end
  end

  // Window counters; dropping ena throws away the partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_r <= {WIN_LOG2{1'b0}};
      ones_r <= {(WIN_LOG2+1){1'b0}};
    end else if (!ena || win_end_s) begin
      wcnt_r <= {WIN_LOG2{1'b0}};
      ones_r <= {(WIN_LOG2+1){1'b0}};
    end else begin
      wcnt_r <= wcnt_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
      ones_r <= total_s;
    end
  end

  // Output sample register: a new window result overwrites the sample, and overrun flags lost data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= {OUT_W{1'b0}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (win_end_s) begin
        out_data  <= scale_total(total_s);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      if (ovr_set_s) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Randomised scoreboard bench for ota_bitstream_decimator. A window-level reference model
// pushes the expected samples, and a negedge monitor compares them against the DUT.
module tb_ota_bitstream_decimator;

  localparam int SYNC = 2;
  localparam int WL2  = 8;
  localparam int OW   = 8;
  localparam int N    = 1 << WL2;
  localparam int MAXV = (1 << OW) - 1;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          bit_in;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          clr_ovr;

  int checks = 0;
  int errors = 0;

  // Reference state: the comparator history, the bits of the current window, and pending samples.
  bit hist[$];
  bit win[$];
  int exp_q[$];
  int exp_data = 0;
  bit exp_ovr  = 1'b0;

  ota_bitstream_decimator #(.SYNC_STAGES(SYNC), .WIN_LOG2(WL2), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bit_in(bit_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies the rules for one clock edge, using the inputs that are stable at that edge.
  task automatic model_edge();
    bit s;
    bit win_end;
    bit consumed;
    bit ovr_set;
    int total;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      win.delete();
      exp_q.delete();
      exp_data = 0;
      exp_ovr  = 1'b0;
      return;
    end
    s = hist.pop_front();
    hist.push_back(bit_in);
    win_end = 1'b0;
    total   = 0;
    if (ena) begin
      win.push_back(s);
      if (win.size() == N) begin
        win_end = 1'b1;
        foreach (win[i]) total += int'(win[i]);
        win.delete();
      end
    end else begin
      win.delete();
    end
    consumed = (exp_q.size() != 0) && out_ready;
    ovr_set  = 1'b0;
    if (win_end) begin
      ovr_set = (exp_q.size() != 0) && !consumed;
      exp_q.delete();
      exp_data = total >> (WL2 - OW);
      if (exp_data > MAXV) exp_data = MAXV;
      exp_q.push_back(exp_data);
    end else if (consumed) begin
      void'(exp_q.pop_front());
    end
    if (ovr_set) exp_ovr = 1'b1;
    else if (clr_ovr) exp_ovr = 1'b0;
  endtask

  task automatic drive(input logic r, input logic e, input logic b, input logic rdy, input logic c);
    rst = r; ena = e; bit_in = b; out_ready = rdy; clr_ovr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares the presented sample, the valid flag and overrun against the model.
  always @(negedge clk) begin
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, exp_q.size() != 0);
    end
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL overrun t=%0t got %b exp %b", $time, overrun, exp_ovr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      if (out_data !== OW'(exp_q[0])) begin
        errors++;
        $display("FAIL sample t=%0t got %0d exp %0d", $time, out_data, exp_q[0]);
      end
    end else if (out_data !== OW'(exp_data)) begin
      errors++;
      $display("FAIL held_data t=%0t got %0d exp %0d", $time, out_data, exp_data);
    end
  end

  initial begin
    logic b;
    int   p;
    b = 1'b0;
    p = 50;
    // Reset with bit_in and ena both high.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // All-ones window that saturates the sample.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N + 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Half-density bitstream with the consumer ready.
    for (int i = 0; i < 3 * N; i++) begin
      b = ~b;
      drive(1'b0, 1'b1, b, 1'b1, 1'b0);
    end
    // Zero density with the consumer always ready.
    for (int i = 0; i < 2 * N; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // Overrun: two windows pass without being consumed.
    for (int i = 0; i < N; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N + 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Abort a window by dropping ena, then abort one by asserting rst.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N + 10; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N + 10; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Random traffic: a density that changes every block, with sparse ena drops and resets.
    for (int i = 0; i < 3000; i++) begin
      logic e;
      logic r;
      if (i % 512 == 0) p = int'($urandom_range(0, 100));
      e = ($urandom_range(0, 199) != 0);
      r = ($urandom_range(0, 999) == 0);
      b = ($urandom_range(0, 99) < p);
      drive(r, e, b, e && ($urandom_range(0, 3) == 0), e && ($urandom_range(0, 31) == 0));
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
